// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencing controller.
// Holds the controller state encoding and the default iteration counts
// for the radix-4 Booth multiplier and the restoring divider.
package multdiv_pkg;

   // Two-bit state encoding shared by the controller and anything that
   // observes it.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MULT_RUN = 2'd1,
      DIV_RUN  = 2'd2,
      DONE     = 2'd3
   } state_t;

   // A 32-bit radix-4 Booth multiply retires two bits per step.
   localparam int MULT_CYCLES_DEF = 16;

   // A 32-bit restoring divide retires one quotient bit per step.
   localparam int DIV_CYCLES_DEF = 32;

   // Wide enough to hold the longest step index (DIV_CYCLES_DEF - 1).
   localparam int CNT_W_DEF = 5;

endpackage

// File: rtl/multdiv_step_cnt.sv
// Iteration counter for the multiply/divide controller.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-high reset, count returns to 0
//   clear  - synchronous clear, asserted when a new op loads its operands
//   en     - advance by one step this cycle
//   limit  - terminal step index for the op in progress
//   count  - current step index
//   tc     - high when count has reached limit
module multdiv_step_cnt
#(
   parameter int CNT_W = 5
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   // The counter stops at the terminal value rather than wrapping, so the
   // last step index stays visible for the whole final step cycle and
   // after the op completes. A load always takes priority so an aborted
   // op restarts from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en && !tc) begin
         count <= count + CNT_W'(1);
      end
   end

   assign tc = (count == limit);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the shared iterative multiplier/divider.
// Accepts single-cycle op requests, drives operand load and per-step
// enables for the datapath, and reports result-ready and exception.
// Ports:
//   clk            - system clock
//   reset          - asynchronous active-high reset, forces IDLE
//   ctrl_MULT      - one-cycle multiply request (wins over ctrl_DIV)
//   ctrl_DIV       - one-cycle divide request
//   div_by_zero    - divisor is zero, valid with ctrl_DIV
//   mult_ovf       - product overflow, valid in the DONE cycle
//   load_operands  - datapath captures operands at the coming edge
//   step_en        - datapath performs one iteration this cycle
//   op_is_div      - registered op select for the datapath muxes
//   count          - current iteration index
//   busy           - an op is iterating
//   data_resultRDY - one-cycle pulse, result valid
//   data_exception - overflow or divide-by-zero, valid with data_resultRDY
module multdiv_ctrl
   import multdiv_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic             div_by_zero,
   input  logic             mult_ovf,
   output logic             load_operands,
   output logic             step_en,
   output logic             op_is_div,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             data_resultRDY,
   output logic             data_exception
);

   localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

   state_t           state;
   logic             dz;
   logic             tc;
   logic [CNT_W-1:0] limit;

   // Operands are captured by the datapath at the same edge the request
   // is sampled, so the load strobe is a plain decode of the request.
   assign load_operands = ctrl_MULT | ctrl_DIV;

   // The terminal step depends on which op is iterating; op_is_div is
   // already settled by the first step cycle.
   assign limit = op_is_div ? DIV_LAST : MULT_LAST;

   multdiv_step_cnt #(
      .CNT_W (CNT_W)
   ) u_step_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (load_operands),
      .en    (step_en),
      .limit (limit),
      .count (count),
      .tc    (tc)
   );

   // Main sequencer. A request is honoured in every state so a new op
   // aborts whatever is in flight. Multiply wins when both requests
   // arrive together. A divide by zero skips the iterations entirely and
   // reports straight from DONE with the latched zero-divisor flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         op_is_div <= 1'b0;
         dz        <= 1'b0;
      end else if (ctrl_MULT) begin
         state     <= MULT_RUN;
         op_is_div <= 1'b0;
      end else if (ctrl_DIV) begin
         op_is_div <= 1'b1;
         dz        <= div_by_zero;
         state     <= div_by_zero ? DONE : DIV_RUN;
      end else begin
         case (state)
            MULT_RUN,
            DIV_RUN:  if (tc) state <= DONE;
            DONE:     state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   // Strobes are pure decodes of the state register, so they drop the
   // moment reset asserts and never glitch on request inputs.
   assign step_en        = (state == MULT_RUN) || (state == DIV_RUN);
   assign busy           = step_en;
   assign data_resultRDY = (state == DONE);

   // Overflow is only known once the product is complete, so it is taken
   // live in the DONE cycle; the divide exception was latched at request.
   assign data_exception = data_resultRDY & (op_is_div ? dz : mult_ovf);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl. A job-based reference model
// predicts every output from the elapsed time since the last request.
module tb_multdiv_ctrl;

   localparam int MULT_N = 16;
   localparam int DIV_N  = 32;

   logic       clk;
   logic       reset;
   logic       ctrl_MULT;
   logic       ctrl_DIV;
   logic       div_by_zero;
   logic       mult_ovf;
   logic       load_operands;
   logic       step_en;
   logic       op_is_div;
   logic [4:0] count;
   logic       busy;
   logic       data_resultRDY;
   logic       data_exception;

   int checkCount;
   int passCount;

   // Reference model: the op in flight is a job with a start cycle and a
   // number of step cycles; everything else follows from elapsed time.
   int   cyc;
   bit   jobActive;
   int   jobStart;
   int   jobLen;
   bit   jobDiv;
   bit   jobDz;
   bit   expOpDiv;
   int   shownCount;
   bit   countKnown;

   multdiv_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .div_by_zero    (div_by_zero),
      .mult_ovf       (mult_ovf),
      .load_operands  (load_operands),
      .step_en        (step_en),
      .op_is_div      (op_is_div),
      .count          (count),
      .busy           (busy),
      .data_resultRDY (data_resultRDY),
      .data_exception (data_exception)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d",
                  tag, cyc, observed, expected);
      end
   endtask

   // Forget any job and return the model to its power-on view.
   task automatic modelReset();
      jobActive  = 1'b0;
      expOpDiv   = 1'b0;
      shownCount = 0;
      countKnown = 1'b1;
   endtask

   // Drive one cycle of inputs, check every output against the model,
   // then let the model absorb any request made this cycle.
   task automatic applyStimulus(input logic m, input logic d,
                                input logic z, input logic o);
      int  e;
      bit  expStep;
      bit  expRdy;
      bit  expExc;
      @(negedge clk);
      ctrl_MULT   = m;
      ctrl_DIV    = d;
      div_by_zero = z;
      mult_ovf    = o;
      #1;
      e       = cyc - jobStart;
      expStep = jobActive && (e >= 1) && (e <= jobLen);
      expRdy  = jobActive && (e == jobLen + 1);
      expExc  = expRdy && (jobDiv ? jobDz : o);
      if (expStep) shownCount = e - 1;
      checkOutput("load_operands",  32'(load_operands),  32'(m | d));
      checkOutput("step_en",        32'(step_en),        32'(expStep));
      checkOutput("busy",           32'(busy),           32'(expStep));
      checkOutput("data_resultRDY", 32'(data_resultRDY), 32'(expRdy));
      checkOutput("data_exception", 32'(data_exception), 32'(expExc));
      checkOutput("op_is_div",      32'(op_is_div),      32'(expOpDiv));
      if (countKnown) checkOutput("count", 32'(count), 32'(shownCount));
      if (expRdy) jobActive = 1'b0;
      if (m || d) begin
         jobActive = 1'b1;
         jobStart  = cyc;
         jobDiv    = !m;
         jobDz     = !m && z;
         jobLen    = m ? MULT_N : (z ? 0 : DIV_N);
         expOpDiv  = !m;
         if (jobDz) begin
            countKnown = 1'b0;
         end else begin
            shownCount = 0;
            countKnown = 1'b1;
         end
      end
      cyc++;
   endtask

   task automatic idleCycles(input int n, input logic o);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, o);
   endtask

   // Assert reset part-way through a cycle: outputs must fall before any
   // clock edge arrives.
   task automatic applyReset();
      @(negedge clk);
      ctrl_MULT   = 1'b0;
      ctrl_DIV    = 1'b0;
      div_by_zero = 1'b0;
      mult_ovf    = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst step_en",        32'(step_en),        32'd0);
      checkOutput("rst busy",           32'(busy),           32'd0);
      checkOutput("rst data_resultRDY", 32'(data_resultRDY), 32'd0);
      checkOutput("rst data_exception", 32'(data_exception), 32'd0);
      checkOutput("rst op_is_div",      32'(op_is_div),      32'd0);
      checkOutput("rst count",          32'(count),          32'd0);
      modelReset();
      @(negedge clk);
      reset = 1'b0;
      cyc++;
   endtask

   // Directed scenarios first, then a long randomized run.
   initial begin
      int r;
      logic m, d, z, o;
      checkCount  = 0;
      passCount   = 0;
      cyc         = 0;
      jobStart    = 0;
      jobLen      = 0;
      jobDiv      = 1'b0;
      jobDz       = 1'b0;
      modelReset();
      reset       = 1'b1;
      ctrl_MULT   = 1'b0;
      ctrl_DIV    = 1'b0;
      div_by_zero = 1'b0;
      mult_ovf    = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("init step_en",        32'(step_en),        32'd0);
      checkOutput("init data_resultRDY", 32'(data_resultRDY), 32'd0);
      checkOutput("init op_is_div",      32'(op_is_div),      32'd0);
      checkOutput("init count",          32'(count),          32'd0);
      reset = 1'b0;

      // Plain multiply, no overflow.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(19, 1'b0);

      // Plain divide.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      idleCycles(35, 1'b0);

      // Multiply with overflow reported in the ready cycle.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      idleCycles(19, 1'b1);

      // Divide by zero completes immediately.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      idleCycles(3, 1'b0);

      // Multiply aborted by a divide five cycles later.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(4, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      idleCycles(36, 1'b0);

      // Both requests together: multiply wins.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      idleCycles(19, 1'b0);

      // Reset in the middle of a divide.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      idleCycles(7, 1'b0);
      applyReset();
      idleCycles(5, 1'b0);

      // New request lands in the DONE cycle of the previous op.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(16, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      idleCycles(35, 1'b0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            applyReset();
         end else begin
            r = int'($urandom_range(0, 99));
            m = (r < 3) || (r == 6);
            d = ((r >= 3) && (r < 6)) || (r == 6);
            z = ($urandom_range(0, 2) == 0);
            o = $urandom_range(0, 1) == 1;
            applyStimulus(m, d, z, o);
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Sequencing controller for the iterative multiplier/divider datapath in proc/multdiv. It accepts single-cycle op requests and drives the datapath's operand load and per-iteration step enables. It counts iterations and reports result-ready and exception to the pipeline stall logic. One controller is shared by the multiply (radix-4 Booth) and divide (restoring) paths.

Parameters:
MULT_CYCLES, 16, number of datapath step cycles for a 32-bit multiply
DIV_CYCLES, 32, number of datapath step cycles for a 32-bit divide
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; forces IDLE immediately
ctrl_MULT  in  1  one-cycle pulse: start multiply, operands valid this cycle only
ctrl_DIV  in  1  one-cycle pulse: start divide, operands valid this cycle only
div_by_zero  in  1  datapath flag, divisor == 0, valid in the ctrl_DIV cycle
mult_ovf  in  1  datapath flag, product overflows 32 bits, valid in DONE cycle
load_operands  out  1  combinational = ctrl_MULT | ctrl_DIV; datapath captures operands at that edge
step_en  out  1  datapath performs one iteration this cycle
op_is_div  out  1  registered op select for datapath muxes
count  out  CNT_W  current iteration index
busy  out  1  high in MULT_RUN or DIV_RUN
data_resultRDY  out  1  one-cycle pulse, result valid on datapath output
data_exception  out  1  valid only while data_resultRDY = 1

Behaviour:
- States: IDLE, MULT_RUN, DIV_RUN, DONE. Reset value: IDLE, count = 0, op_is_div = 0, dz latch = 0. All registered outputs reset to 0. load_operands follows its inputs combinationally.
- Request decode applies in any state. A new request aborts any op in flight and restarts.
  - ctrl_MULT = 1: next state MULT_RUN, op_is_div <= 0, count <= 0.
  - ctrl_DIV = 1, ctrl_MULT = 0, div_by_zero = 0: next state DIV_RUN, op_is_div <= 1, count <= 0, dz <= 0.
  - ctrl_DIV = 1, ctrl_MULT = 0, div_by_zero = 1: next state DONE directly, op_is_div <= 1, dz <= 1. No step_en is issued.
  - ctrl_MULT and ctrl_DIV both high: multiply wins; the divide request is dropped.
- MULT_RUN / DIV_RUN:
  - step_en = 1 and count increments each cycle.
  - When count == N-1 (N = MULT_CYCLES or DIV_CYCLES), next state is DONE and count holds at N-1.
  - step_en is therefore high for exactly N consecutive cycles.
- DONE: data_resultRDY = 1 for exactly one cycle, then IDLE.
  - data_exception = mult_ovf when op_is_div = 0.
  - data_exception = dz when op_is_div = 1.
- IDLE: all strobes 0; count holds its last value.
- Latency, with the request at cycle 0:
  - multiply: step_en cycles 1..16, data_resultRDY cycle 17.
  - divide: step_en cycles 1..32, data_resultRDY cycle 33.
  - divide by zero: data_resultRDY cycle 1, data_exception = 1.
- Outside DONE, data_resultRDY = 0 and data_exception = 0.
- Count wrap is unreachable; the terminal compare stops it at N-1.
- Reset asserted mid-operation: immediate IDLE, step_en and data_resultRDY drop without waiting for clk. No spurious ready after deassertion.
- Request in the same cycle as DONE: the ready pulse for the old op still fires that cycle, and the new op starts next cycle.

Decomposition:
- multdiv_pkg holds:
  - the state encoding (2-bit: IDLE = 0, MULT_RUN = 1, DIV_RUN = 2, DONE = 3)
  - the MULT_CYCLES and DIV_CYCLES defaults
  - the CNT_W constant
- One sub-module, multdiv_step_cnt: CNT_W-bit up-counter with async reset, synchronous clear (on load), enable (step_en), and terminal-count output compared against a run-time limit.
- The FSM and exception latch stay in multdiv_ctrl.

Test Plan:
- Reset then ctrl_MULT pulse at cycle 0, mult_ovf = 0 -> step_en high cycles 1..16, count 0..15, data_resultRDY = 1 only at cycle 17, data_exception = 0, busy high cycles 1..16.
- ctrl_DIV pulse, div_by_zero = 0 -> step_en high exactly 32 cycles, op_is_div = 1, data_resultRDY at cycle 33; repeat with mult_ovf = 1 on a multiply -> data_exception = 1 at cycle 17.
- ctrl_DIV with div_by_zero = 1 -> no step_en, data_resultRDY = 1 and data_exception = 1 at cycle 1, IDLE at cycle 2.
- ctrl_MULT at cycle 0, then ctrl_DIV at cycle 5 -> load_operands high at cycles 0 and 5, count restarts at 0, single data_resultRDY at cycle 38, none at cycle 17.
- ctrl_MULT and ctrl_DIV high together -> op_is_div = 0, 16 step cycles; reset asserted at cycle 8 mid-DIV_RUN -> step_en = 0 the same cycle, no data_resultRDY after release.
